// File: rtl/lsu_arbiter.sv
// Purpose: round-robin share of one load/store unit between port 0 (core) and port 1 (debug/DMA).
// Latency: accept at N, LSU access at N+1, read sample at N+2, rsp_valid pulse at N+3; one access per 3 cycles.
// Backpressure: req_ready is offered only in IDLE and only to the granted port; responses cannot be stalled.
module lsu_arbiter #(
  parameter logic [31:0] PARK_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_valid_i,
  output logic        p0_req_ready_o,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic        p0_we_i,
  output logic        p0_rsp_valid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_valid_i,
  output logic        p1_req_ready_o,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  input  logic        p1_we_i,
  output logic        p1_rsp_valid_o,
  output logic [31:0] p1_rdata_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  output logic        lsu_st_en_o,
  input  logic [31:0] lsu_ld_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q;        // port preferred when both request
  logic        grant_vld;
  logic        grant_port;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        port_q;

  // Arbitration, next state and LSU drive; idle/read cycles feed load data back as store data
  always_comb begin
    state_d        = state_q;
    grant_vld      = 1'b0;
    grant_port     = 1'b0;
    p0_req_ready_o = 1'b0;
    p1_req_ready_o = 1'b0;
    lsu_addr_o     = PARK_ADDR;
    lsu_st_en_o    = 1'b0;
    lsu_st_data_o  = lsu_ld_data_i;
    case (state_q)
      IDLE: begin
        if (p0_req_valid_i && p1_req_valid_i) begin
          grant_vld  = 1'b1;
          grant_port = rr_q;
        end else if (p0_req_valid_i) begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end else if (p1_req_valid_i) begin
          grant_vld  = 1'b1;
          grant_port = 1'b1;
        end
        p0_req_ready_o = grant_vld && !grant_port;
        p1_req_ready_o = grant_vld && grant_port;
        if (grant_vld) state_d = ISSUE;
      end
      ISSUE: begin
        lsu_addr_o    = addr_q;
        lsu_st_en_o   = we_q;
        lsu_st_data_o = we_q ? wdata_q : lsu_ld_data_i;
        state_d       = RESP;
      end
      RESP: begin
        lsu_addr_o = addr_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch the granted request and hand preference to the other port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
    end else if (grant_vld) begin
      rr_q    <= ~grant_port;
      addr_q  <= grant_port ? p1_addr_i  : p0_addr_i;
      wdata_q <= grant_port ? p1_wdata_i : p0_wdata_i;
      we_q    <= grant_port ? p1_we_i    : p0_we_i;
      port_q  <= grant_port;
    end
  end

  // Sample load data at the end of RESP and pulse the owning port for one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p0_rsp_valid_o <= 1'b0;
      p1_rsp_valid_o <= 1'b0;
      p0_rdata_o     <= 32'h0;
      p1_rdata_o     <= 32'h0;
    end else begin
      p0_rsp_valid_o <= 1'b0;
      p1_rsp_valid_o <= 1'b0;
      if (state_q == RESP) begin
        if (port_q) begin
          p1_rsp_valid_o <= 1'b1;
          p1_rdata_o     <= lsu_ld_data_i;
        end else begin
          p0_rsp_valid_o <= 1'b1;
          p0_rdata_o     <= lsu_ld_data_i;
        end
      end
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: hand sequences, an arbitration vector table and a randomized run
// against a transaction-level model. A small LSU model with data memory, LEDR and switches
// sits behind the arbiter; output peripherals capture st_data on every edge regardless of st_en.
module tb_lsu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        p0_req_valid_i = 1'b0, p1_req_valid_i = 1'b0;
  logic        p0_req_ready_o, p1_req_ready_o;
  logic [31:0] p0_addr_i = '0, p0_wdata_i = '0, p1_addr_i = '0, p1_wdata_i = '0;
  logic        p0_we_i = 1'b0, p1_we_i = 1'b0;
  logic        p0_rsp_valid_o, p1_rsp_valid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic [31:0] lsu_addr_o, lsu_st_data_o, lsu_ld_data_i;
  logic        lsu_st_en_o, busy_o;

  lsu_arbiter #(.PARK_ADDR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_req_valid_i(p0_req_valid_i), .p0_req_ready_o(p0_req_ready_o),
    .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_we_i(p0_we_i),
    .p0_rsp_valid_o(p0_rsp_valid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_valid_i(p1_req_valid_i), .p1_req_ready_o(p1_req_ready_o),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_we_i(p1_we_i),
    .p1_rsp_valid_o(p1_rsp_valid_o), .p1_rdata_o(p1_rdata_o),
    .lsu_addr_o(lsu_addr_o), .lsu_st_data_o(lsu_st_data_o), .lsu_st_en_o(lsu_st_en_o),
    .lsu_ld_data_i(lsu_ld_data_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // LSU model: 12-bit decode with upper-address aliasing
  logic [31:0] mem [256];
  logic [31:0] ledr = 32'h0;
  logic [31:0] sw   = 32'h0;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  always_comb begin
    lsu_ld_data_i = mem[lsu_addr_o[9:2]];
    if (lsu_addr_o[11:0] == 12'h880)      lsu_ld_data_i = ledr;
    else if (lsu_addr_o[11:8] == 4'h9)    lsu_ld_data_i = sw;
  end

  always @(posedge clk_i) begin
    if (lsu_addr_o[11:0] == 12'h880) ledr <= lsu_st_data_o;
    if (lsu_st_en_o && !lsu_addr_o[11]) mem[lsu_addr_o[9:2]] <= lsu_st_data_o;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    p0_req_valid_i = 1'b0; p1_req_valid_i = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  // One complete access with per-cycle checks; expects to be called with the arbiter idle or soon idle
  task automatic do_access(input bit port, input logic [31:0] a, input logic [31:0] wd,
                           input bit we, input logic [31:0] exp, input string tag);
    bit got;
    got = 1'b0;
    if (port) begin p1_req_valid_i = 1; p1_addr_i = a; p1_wdata_i = wd; p1_we_i = we; end
    else      begin p0_req_valid_i = 1; p0_addr_i = a; p0_wdata_i = wd; p0_we_i = we; end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (port ? p1_req_ready_o : p0_req_ready_o) begin got = 1'b1; break; end
      tick();
    end
    chk({tag, "_accept"}, {31'h0, got}, 32'h1);
    chk({tag, "_other_ready"}, {31'h0, port ? p0_req_ready_o : p1_req_ready_o}, 32'h0);
    tick();
    p0_req_valid_i = 0; p1_req_valid_i = 0;
    p0_addr_i = 32'h0000_0ABC; p1_addr_i = 32'h0000_0ABC; p0_wdata_i = '1; p1_wdata_i = '1;
    @(negedge clk_i);
    chk({tag, "_issue_st_en"}, {31'h0, lsu_st_en_o}, {31'h0, we});
    chk({tag, "_issue_addr"}, lsu_addr_o, a);
    tick();
    @(negedge clk_i);
    chk({tag, "_resp_st_en"}, {31'h0, lsu_st_en_o}, 32'h0);
    chk({tag, "_resp_busy"}, {31'h0, busy_o}, 32'h1);
    tick();
    @(negedge clk_i);
    chk({tag, "_rsp_valid"}, {31'h0, port ? p1_rsp_valid_o : p0_rsp_valid_o}, 32'h1);
    chk({tag, "_other_rsp"}, {31'h0, port ? p0_rsp_valid_o : p1_rsp_valid_o}, 32'h0);
    chk({tag, "_rdata"}, port ? p1_rdata_o : p0_rdata_o, exp);
    chk({tag, "_park_addr"}, lsu_addr_o, 32'h0);
    tick();
  endtask

  typedef struct {
    logic p0v, p1v, r0, r1, busy, rsp0, rsp1;
  } vec_t;
  vec_t tbl [20];

  // Random-phase reference model state
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rd [2];
  int          since_acc, acc_cyc, pend_due;
  bit          last_g, acc_we, pend_vld, pend_port;
  logic [31:0] pend_data;

  initial begin
    tbl[0]  = '{1,1, 1,0, 0, 0,0};
    tbl[1]  = '{1,1, 0,0, 1, 0,0};
    tbl[2]  = '{1,1, 0,0, 1, 0,0};
    tbl[3]  = '{1,1, 0,1, 0, 1,0};
    tbl[4]  = '{1,1, 0,0, 1, 0,0};
    tbl[5]  = '{0,1, 0,0, 1, 0,0};
    tbl[6]  = '{0,1, 0,1, 0, 0,1};
    tbl[7]  = '{1,1, 0,0, 1, 0,0};
    tbl[8]  = '{1,1, 0,0, 1, 0,0};
    tbl[9]  = '{1,1, 1,0, 0, 0,1};
    tbl[10] = '{1,0, 0,0, 1, 0,0};
    tbl[11] = '{1,0, 0,0, 1, 0,0};
    tbl[12] = '{1,0, 1,0, 0, 1,0};
    tbl[13] = '{0,0, 0,0, 1, 0,0};
    tbl[14] = '{0,0, 0,0, 1, 0,0};
    tbl[15] = '{0,0, 0,0, 0, 1,0};
    tbl[16] = '{1,1, 0,1, 0, 0,0};
    tbl[17] = '{0,0, 0,0, 1, 0,0};
    tbl[18] = '{0,0, 0,0, 1, 0,0};
    tbl[19] = '{0,0, 0,0, 0, 0,1};

    // Reset state
    #3;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    do_reset();
    @(negedge clk_i);
    chk("rst_rsp0", {31'h0, p0_rsp_valid_o}, 32'h0);
    chk("rst_rsp1", {31'h0, p1_rsp_valid_o}, 32'h0);
    chk("rst_rdata0", p0_rdata_o, 32'h0);
    chk("rst_rdata1", p1_rdata_o, 32'h0);
    chk("rst_ready0", {31'h0, p0_req_ready_o}, 32'h0);
    chk("rst_park", lsu_addr_o, 32'h0);
    chk("rst_st_en", {31'h0, lsu_st_en_o}, 32'h0);
    tick();

    // Store then load on port 0
    do_access(1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "p0_wr");
    do_access(1'b0, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF, "p0_rd");

    // LEDR write from port 1, read back from port 0, then idle must not clobber it
    do_access(1'b1, 32'h880, 32'h0000_00FF, 1'b1, 32'h0000_00FF, "p1_ledr_wr");
    do_access(1'b0, 32'h880, 32'h0, 1'b0, 32'h0000_00FF, "p0_ledr_rd");
    tick(); tick(); tick();
    chk("ledr_kept", ledr, 32'h0000_00FF);
    chk("ledr_rdata0", p0_rdata_o, 32'h0000_00FF);
    chk("ledr_rdata1_held", p1_rdata_o, 32'h0000_00FF);

    // Switch read
    sw = 32'h0000_0155;
    do_access(1'b0, 32'h9FF, 32'h0, 1'b0, 32'h0000_0155, "p0_sw_rd");
    chk("sw_rdata1_held", p1_rdata_o, 32'h0000_00FF);

    // Arbitration table, starting from reset so port 0 is preferred
    do_reset();
    p0_addr_i = 32'h100; p0_we_i = 0; p1_addr_i = 32'h104; p1_we_i = 0;
    for (int i = 0; i < 20; i++) begin
      p0_req_valid_i = tbl[i].p0v;
      p1_req_valid_i = tbl[i].p1v;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ready0", i), {31'h0, p0_req_ready_o}, {31'h0, tbl[i].r0});
      chk($sformatf("tbl%0d_ready1", i), {31'h0, p1_req_ready_o}, {31'h0, tbl[i].r1});
      chk($sformatf("tbl%0d_busy", i), {31'h0, busy_o}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_rsp0", i), {31'h0, p0_rsp_valid_o}, {31'h0, tbl[i].rsp0});
      chk($sformatf("tbl%0d_rsp1", i), {31'h0, p1_rsp_valid_o}, {31'h0, tbl[i].rsp1});
      tick();
    end
    p0_req_valid_i = 0; p1_req_valid_i = 0;
    tick();

    // Asynchronous reset during RESP of a port 0 read
    p0_req_valid_i = 1; p0_addr_i = 32'h100; p0_we_i = 0;
    @(negedge clk_i);
    chk("arst_accept", {31'h0, p0_req_ready_o}, 32'h1);
    tick();
    p0_req_valid_i = 0;
    tick();
    @(negedge clk_i);
    chk("arst_in_resp", {31'h0, busy_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk("arst_busy_now", {31'h0, busy_o}, 32'h0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("arst_no_rsp0", {31'h0, p0_rsp_valid_o}, 32'h0);
      tick();
    end
    p0_req_valid_i = 1; p1_req_valid_i = 1; p1_addr_i = 32'h104; p1_we_i = 0;
    @(negedge clk_i);
    chk("arst_pref_p0", {31'h0, p0_req_ready_o}, 32'h1);
    chk("arst_pref_not_p1", {31'h0, p1_req_ready_o}, 32'h0);
    tick();
    p0_req_valid_i = 0; p1_req_valid_i = 0;
    tick(); tick(); tick();

    // Port 0 asserts valid for one cycle while port 1 is in flight, then withdraws
    p1_req_valid_i = 1; p1_addr_i = 32'h104; p1_we_i = 0;
    @(negedge clk_i);
    chk("drop_p1_accept", {31'h0, p1_req_ready_o}, 32'h1);
    tick();
    p1_req_valid_i = 0;
    p0_req_valid_i = 1; p0_addr_i = 32'h108; p0_we_i = 1; p0_wdata_i = 32'h1234_5678;
    @(negedge clk_i);
    chk("drop_p0_not_ready", {31'h0, p0_req_ready_o}, 32'h0);
    chk("drop_issue_addr", lsu_addr_o, 32'h104);
    tick();
    p0_req_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("drop_no_rsp0", {31'h0, p0_rsp_valid_o}, 32'h0);
      chk("drop_no_st_en", {31'h0, lsu_st_en_o}, 32'h0);
      if (i == 1) chk("drop_rsp1", {31'h0, p1_rsp_valid_o}, 32'h1);
      if (i >= 2) chk("drop_idle", {31'h0, busy_o}, 32'h0);
      tick();
    end
    chk("drop_mem_untouched", mem[8'h42], 32'h0);

    // Randomized traffic against a transaction-level model
    do_reset();
    exp_rd[0] = '0; exp_rd[1] = '0;
    since_acc = 3; acc_cyc = -100; last_g = 1'b1; acc_we = 0; pend_vld = 0;
    pend_port = 0; pend_due = 0; pend_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit er0, er1, g, we;
      logic [31:0] a, wd, d;
      p0_req_valid_i = ($urandom_range(0, 2) != 0);
      p1_req_valid_i = ($urandom_range(0, 2) != 0);
      p0_addr_i = 32'h200 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      p1_addr_i = 32'h200 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      p0_we_i = $urandom_range(0, 1) != 0;
      p1_we_i = $urandom_range(0, 1) != 0;
      p0_wdata_i = $urandom;
      p1_wdata_i = $urandom;
      @(negedge clk_i);
      er0 = 0; er1 = 0;
      if (since_acc >= 3) begin
        if (p0_req_valid_i && p1_req_valid_i) begin
          if (last_g) er0 = 1; else er1 = 1;
        end else if (p0_req_valid_i) er0 = 1;
        else if (p1_req_valid_i) er1 = 1;
      end
      if (pend_vld && pend_due == cyc) begin
        exp_rd[pend_port] = pend_data;
        chk("rnd_rsp0", {31'h0, p0_rsp_valid_o}, {31'h0, !pend_port});
        chk("rnd_rsp1", {31'h0, p1_rsp_valid_o}, {31'h0, pend_port});
        pend_vld = 0;
      end else begin
        chk("rnd_rsp0", {31'h0, p0_rsp_valid_o}, 32'h0);
        chk("rnd_rsp1", {31'h0, p1_rsp_valid_o}, 32'h0);
      end
      chk("rnd_rdata0", p0_rdata_o, exp_rd[0]);
      chk("rnd_rdata1", p1_rdata_o, exp_rd[1]);
      chk("rnd_ready0", {31'h0, p0_req_ready_o}, {31'h0, er0});
      chk("rnd_ready1", {31'h0, p1_req_ready_o}, {31'h0, er1});
      chk("rnd_busy", {31'h0, busy_o}, {31'h0, (since_acc == 1 || since_acc == 2)});
      chk("rnd_st_en", {31'h0, lsu_st_en_o}, {31'h0, (acc_cyc + 1 == cyc) && acc_we});
      if (er0 || er1) begin
        g  = er1;
        a  = g ? p1_addr_i  : p0_addr_i;
        wd = g ? p1_wdata_i : p0_wdata_i;
        we = g ? p1_we_i    : p0_we_i;
        if (we) begin
          ref_mem[a] = wd;
          d = wd;
        end else begin
          d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        end
        pend_vld = 1; pend_port = g; pend_due = cyc + 3; pend_data = d;
        last_g = g; since_acc = 0; acc_cyc = cyc; acc_we = we;
      end
      since_acc++;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
Shares the single load/store unit between two requesters: port 0 (core data port) and port 1 (debug/DMA port). Round-robin arbitration, valid/ready request handshake, one-cycle response pulse. Sequences each access as ISSUE then RESP so the LSU's registered read data is sampled at a stable address. Keeps output-peripheral registers unchanged on reads and while idle.

Parameters:
PARK_ADDR, 32'h0000_0000, address driven to the LSU while idle; must decode to data memory, not a peripheral.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
p0_req_valid_i  in  1  port 0 request valid
p0_req_ready_o  out  1  port 0 request accepted this cycle
p0_addr_i  in  32  port 0 byte address
p0_wdata_i  in  32  port 0 store data
p0_we_i  in  1  port 0 write (1) / read (0)
p0_rsp_valid_o  out  1  port 0 response pulse
p0_rdata_o  out  32  port 0 response data
p1_*  (same six signals for port 1)
lsu_addr_o  out  32  LSU address
lsu_st_data_o  out  32  LSU store data
lsu_st_en_o  out  1  LSU store enable
lsu_ld_data_i  in  32  LSU load data (combinational from LSU registers)
busy_o  out  1  high in ISSUE and RESP

Behaviour:
- Interface: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset: state=IDLE, rr_ptr=0 (port 0 preferred), p*_rsp_valid_o=0, p*_rdata_o=0, latched request cleared, busy_o=0.
- FSM states:
  - IDLE: if any valid, grant one port and assert its req_ready_o combinationally in the same cycle. Latch addr, wdata, we and port id. Next state ISSUE. With no valid request, stay in IDLE.
  - ISSUE: go to RESP.
  - RESP: go to IDLE.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the port not granted last. rr_ptr is updated at each grant.
  - Never assert both ready signals in the same cycle.
- LSU drive:
  - IDLE: lsu_addr_o=PARK_ADDR, lsu_st_en_o=0, lsu_st_data_o=lsu_ld_data_i.
  - ISSUE: lsu_addr_o=latched addr, lsu_st_en_o=latched we. lsu_st_data_o=latched wdata if we, else lsu_ld_data_i.
  - RESP: lsu_addr_o=latched addr (held), lsu_st_en_o=0, lsu_st_data_o=lsu_ld_data_i.
  - Reason for the feedback path: the LSU writes st_data to any addressed output peripheral regardless of st_en. Driving back its current value makes reads and the RESP cycle value-preserving. The path is combinational; there is no loop because ld_data depends only on LSU registers and the address.
- Response:
  - At the RESP clock edge, capture lsu_ld_data_i into rdata of the granted port. Pulse that port's rsp_valid_o high for exactly one cycle, the cycle after RESP.
  - Write responses return the written value.
  - The rdata of the other port holds its previous value.
- Latency and throughput:
  - Accept at cycle N (ready high). ISSUE at N+1, RESP at N+2, rsp_valid_o at N+3.
  - A new accept may occur in the same cycle as rsp_valid_o, giving one access per 3 cycles.
- Requester rules: addr/wdata/we are sampled only at the accept edge and may change afterward. A requester may drop valid without being accepted; nothing is issued for it.
- Reset mid-access: the FSM returns to IDLE immediately and no response is produced. A store in ISSUE may or may not have reached the LSU.
- Address handling: addresses are passed through unmodified. No alignment check; the LSU's upper-address aliasing applies.

Test Plan:
- Reset, then p0 write 0xDEAD_BEEF to 0x100, then p0 read 0x100 -> p0_ready at N, lsu_st_en_o=1 only at N+1, p0_rsp_valid_o at N+3 with rdata 0xDEAD_BEEF on both write and read. p1_rsp_valid_o stays 0.
- p0 and p1 both continuously valid (p0 read 0x100, p1 read 0x104) for 12 cycles after reset -> grants strictly alternate p0,p1,p0,p1. Accepts are spaced 3 cycles apart. Ready is never asserted on both ports at once.
- p1 write 0x0000_00FF to LEDR (0x880), then p0 read 0x880, then 3 idle cycles -> read returns 0x0000_00FF. The LEDR value is unchanged at the end: idle parking and read feedback must not clobber it.
- Switch input = 0x0000_0155, p0 read 0x9FF -> p0_rdata_o=0x0000_0155 at N+3.
- rst_i asserted asynchronously during RESP of a p0 read -> no p0_rsp_valid_o pulse. busy_o=0 immediately. The next request is accepted normally, with port 0 preferred.
- p0 valid for 1 cycle while p1 is already granted (p0 not accepted), then p0 drops valid -> no LSU access and no response for p0.
